// File: rtl/xadc_avg_sequencer.sv
// Round-robin XADC DRP channel sequencer with per-channel boxcar averaging onto a valid/ready stream.
// Optional build macro XADC_SEQ_NOISE_FLOOR_EN: samples <= FLOOR are zeroed before accumulation.
module xadc_avg_sequencer #(
    parameter int unsigned       NCH      = 4,
    parameter int unsigned       AVG_LOG2 = 4,
    parameter int unsigned       DATA_W   = 12,
    parameter logic [NCH*7-1:0]  CH_ADDR  = {7'h16, 7'h1f, 7'h17, 7'h1e},
    parameter logic [DATA_W-1:0] FLOOR    = 12'h00F
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    ch_en,
    input  logic              eoc,
    output logic [6:0]        drp_daddr,
    output logic              drp_den,
    input  logic [15:0]       drp_do,
    input  logic              drp_drdy,
    output logic              avg_valid,
    input  logic              avg_ready,
    output logic [2:0]        avg_ch,
    output logic [DATA_W-1:0] avg_data,
    output logic              overrun,
    input  logic              overrun_clr
);

    localparam int unsigned CUR_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
    localparam int unsigned CNT_W = AVG_LOG2 + 1;

`ifdef XADC_SEQ_NOISE_FLOOR_EN
    localparam bit FLOOR_EN = 1'b1;
`else
    localparam bit FLOOR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_EOC,
        S_READ,
        S_WAIT_DRDY,
        S_ACCUM
    } state_t;

    state_t            r_state;
    logic [CUR_W-1:0]  r_cur;
    logic [7:0]        r_tmo;
    logic [DATA_W-1:0] r_sample;
    logic [ACC_W-1:0]  r_acc [NCH];
    logic [CNT_W-1:0]  r_cnt [NCH];
    logic              r_den;
    logic [6:0]        r_daddr;
    logic              r_valid;
    logic [2:0]        r_ch;
    logic [DATA_W-1:0] r_data;
    logic              r_ovr;

    logic [DATA_W-1:0] w_raw;
    logic [DATA_W-1:0] w_sample;
    logic [CUR_W-1:0]  w_next;
    logic [CUR_W-1:0]  w_low;
    logic [6:0]        w_addr_tab [NCH];
    logic [ACC_W-1:0]  w_sum;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_done;
    logic [DATA_W-1:0] w_avg;
    logic              w_unused_drp;

    assign w_raw        = drp_do[15 -: DATA_W];
    assign w_unused_drp = ^drp_do;
    assign w_sample     = (FLOOR_EN && (w_raw <= FLOOR)) ? '0 : w_raw;

    for (genvar g = 0; g < NCH; g++) begin : g_addr
        assign w_addr_tab[g] = CH_ADDR[g*7 +: 7];
    end

    // Next enabled channel strictly after r_cur; the k == NCH probe lands on r_cur itself.
    always_comb begin
        logic [CUR_W-1:0] idx;
        logic             found;
        w_next = r_cur;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            idx = CUR_W'((32'(r_cur) + k) % NCH);
            if (!found && ch_en[idx]) begin
                w_next = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        w_low = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (ch_en[CUR_W'(NCH - 1 - i)]) w_low = CUR_W'(NCH - 1 - i);
        end
    end

    assign w_sum     = r_acc[r_cur] + ACC_W'(r_sample);
    assign w_cnt_inc = r_cnt[r_cur] + 1'b1;
    assign w_done    = (w_cnt_inc == CNT_W'(2 ** AVG_LOG2));
    assign w_avg     = DATA_W'(w_sum >> AVG_LOG2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cur    <= '0;
            r_tmo    <= '0;
            r_sample <= '0;
            r_den    <= 1'b0;
            r_daddr  <= CH_ADDR[6:0];
            r_valid  <= 1'b0;
            r_ch     <= '0;
            r_data   <= '0;
            r_ovr    <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                r_acc[CUR_W'(i)] <= '0;
                r_cnt[CUR_W'(i)] <= '0;
            end
        end else begin
            r_den <= 1'b0;
            if (r_valid && avg_ready) r_valid <= 1'b0;
            if (overrun_clr)          r_ovr   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (|ch_en) begin
                        r_cur   <= w_low;
                        r_state <= S_WAIT_EOC;
                    end
                end
                S_WAIT_EOC: begin
                    if (ch_en == '0) begin
                        r_state <= S_IDLE;
                    end else if (!ch_en[r_cur]) begin
                        r_cur <= w_next;
                    end else if (eoc) begin
                        r_den   <= 1'b1;
                        r_daddr <= w_addr_tab[r_cur];
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_tmo   <= '0;
                    r_state <= S_WAIT_DRDY;
                end
                S_WAIT_DRDY: begin
                    if (drp_drdy) begin
                        r_sample <= w_sample;
                        r_state  <= S_ACCUM;
                    end else if (r_tmo == 8'd254) begin
                        r_state <= S_WAIT_EOC;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                S_ACCUM: begin
                    if (ch_en[r_cur]) begin
                        if (w_done) begin
                            r_acc[r_cur] <= '0;
                            r_cnt[r_cur] <= '0;
                            if (!r_valid || avg_ready) begin
                                r_valid <= 1'b1;
                                r_ch    <= 3'(r_cur);
                                r_data  <= w_avg;
                            end else begin
                                r_ovr <= 1'b1;
                            end
                        end else begin
                            r_acc[r_cur] <= w_sum;
                            r_cnt[r_cur] <= w_cnt_inc;
                        end
                    end
                    r_cur   <= w_next;
                    r_state <= S_WAIT_EOC;
                end
                default: r_state <= S_IDLE;
            endcase

            // Disabled channels are held at zero; this overrides any update above.
            for (int unsigned i = 0; i < NCH; i++) begin
                if (!ch_en[CUR_W'(i)]) begin
                    r_acc[CUR_W'(i)] <= '0;
                    r_cnt[CUR_W'(i)] <= '0;
                end
            end
        end
    end

    assign drp_den   = r_den;
    assign drp_daddr = r_daddr;
    assign avg_valid = r_valid;
    assign avg_ch    = r_ch;
    assign avg_data  = r_data;
    assign overrun   = r_ovr;

endmodule

// File: tb/tb_xadc_avg_sequencer.sv
// Scoreboard bench for xadc_avg_sequencer: DRP responder feeds a per-channel averaging model,
// a separate monitor pops expected results on every output handshake.
`timescale 1ns/1ps
module tb_xadc_avg_sequencer;
    localparam int NCH      = 4;
    localparam int AVG_LOG2 = 4;
    localparam int DATA_W   = 12;
    localparam int NSAMP    = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ch_en;
    logic        eoc, eoc_gen, eoc_man;
    logic [6:0]  drp_daddr;
    logic        drp_den;
    logic [15:0] drp_do;
    logic        drp_drdy;
    logic        avg_valid, avg_ready;
    logic [2:0]  avg_ch;
    logic [11:0] avg_data;
    logic        overrun, overrun_clr;

    assign eoc = eoc_gen | eoc_man;
    always #5 clk = ~clk;

    xadc_avg_sequencer #(.NCH(NCH), .AVG_LOG2(AVG_LOG2), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .eoc(eoc),
        .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_do(drp_do), .drp_drdy(drp_drdy),
        .avg_valid(avg_valid), .avg_ready(avg_ready), .avg_ch(avg_ch), .avg_data(avg_data),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    logic [6:0]  ADDR [4] = '{7'h1e, 7'h17, 7'h1f, 7'h16};
    int          errors = 0;
    int          checks = 0;
    logic [14:0] exp_q [$];
    int          m_sum [4];
    int          m_cnt [4];
    logic [1:0]  exp_ch = 2'd0;
    bit          fresh = 1'b1;
    bit          drop_mode = 1'b0, held = 1'b0, exp_ovr = 1'b0;
    bit          eoc_run = 1'b0, withhold = 1'b0, fixed_en = 1'b0;
    logic [15:0] fixed_data = 16'h0;
    int          ready_mode = 1;
    int          n_den = 0, n_ok = 0, epoch = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [1:0] succ(input logic [1:0] c, input logic [3:0] m);
        logic [1:0] idx;
        for (int k = 1; k <= 4; k++) begin
            idx = 2'((int'(c) + k) % 4);
            if (m[idx]) return idx;
        end
        return c;
    endfunction

    function automatic logic [1:0] lowest(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) if (m[2'(i)]) r = 2'(i);
        return r;
    endfunction

    // Reference model: one successful read adds one sample to the channel that was due.
    task automatic model_sample(input logic [15:0] d);
        int v;
        v = int'(d[15:4]);
`ifdef XADC_SEQ_NOISE_FLOOR_EN
        if (v <= 15) v = 0;
`endif
        m_sum[exp_ch] += v;
        m_cnt[exp_ch] += 1;
        if (m_cnt[exp_ch] == NSAMP) begin
            if (drop_mode && held) exp_ovr = 1'b1;
            else begin
                exp_q.push_back({3'(exp_ch), 12'(m_sum[exp_ch] / NSAMP)});
                if (drop_mode) held = 1'b1;
            end
            m_sum[exp_ch] = 0;
            m_cnt[exp_ch] = 0;
        end
        exp_ch = succ(exp_ch, ch_en);
    endtask

    task automatic set_mask(input logic [3:0] m);
        ch_en = m;
        for (int i = 0; i < 4; i++) if (!m[2'(i)]) begin m_sum[2'(i)] = 0; m_cnt[2'(i)] = 0; end
        if (m == 4'b0) fresh = 1'b1;
        else if (fresh) begin exp_ch = lowest(m); fresh = 1'b0; end
        else if (!m[exp_ch]) exp_ch = succ(exp_ch, m);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_reads(input int n);
        int target, t;
        target = n_ok + n;
        t = 0;
        while (n_ok < target && t < 20000) begin @(negedge clk); t++; end
        check("reads_done", 32'(n_ok >= target), 32'(1));
    endtask

    task automatic quiesce();
        eoc_run = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || avg_valid) && t < 1000) begin @(negedge clk); t++; end
        check("results_pending", 32'(exp_q.size()), 32'(0));
        check("overrun", 32'(overrun), 32'(exp_ovr));
    endtask

    task automatic pulse_eoc();
        eoc_man = 1'b1;
        @(negedge clk);
        eoc_man = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_den"},   32'(drp_den),   32'(0));
        check({tag, "_daddr"}, 32'(drp_daddr), 32'(ADDR[0]));
        check({tag, "_valid"}, 32'(avg_valid), 32'(0));
        check({tag, "_ch"},    32'(avg_ch),    32'(0));
        check({tag, "_data"},  32'(avg_data),  32'(0));
        check({tag, "_ovr"},   32'(overrun),   32'(0));
    endtask

    initial begin : eoc_source
        eoc_gen = 1'b0;
        forever begin
            @(negedge clk);
            eoc_gen = eoc_run && ($urandom_range(0, 2) == 0);
        end
    end

    initial begin : ready_drv
        avg_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            avg_ready = (ready_mode == 2) || (ready_mode == 1 && $urandom_range(0, 3) != 0);
        end
    end

    initial begin : drp_responder
        logic [15:0] d;
        int ep;
        drp_drdy = 1'b0;
        drp_do   = 16'h0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && drp_den === 1'b1) begin
                n_den++;
                check("drp_daddr", 32'(drp_daddr), 32'(ADDR[exp_ch]));
                if (!withhold) begin
                    ep = epoch;
                    repeat ($urandom_range(1, 4)) @(negedge clk);
                    d = fixed_en ? fixed_data : 16'($urandom);
                    drp_do   = d;
                    drp_drdy = 1'b1;
                    @(negedge clk);
                    drp_drdy = 1'b0;
                    if (ep == epoch) begin
                        model_sample(d);
                        n_ok++;
                    end
                end
            end
        end
    end

    initial begin : monitor
        logic [14:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && avg_valid && avg_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got ch %0d data %0h, required no result", avg_ch, avg_data);
                end else begin
                    e = exp_q.pop_front();
                    check("avg_ch", 32'(avg_ch), 32'(e[14:12]));
                    check("avg_data", 32'(avg_data), 32'(e[11:0]));
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [3:0] m;
        int den0, t;
        rst_n = 1'b0; ch_en = 4'b0; eoc_man = 1'b0; overrun_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin m_sum[2'(i)] = 0; m_cnt[2'(i)] = 0; end
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Single channel, constant mid-scale samples.
        fixed_en = 1'b1; fixed_data = 16'h8000;
        set_mask(4'b0001); eoc_run = 1'b1; wait_reads(16); quiesce(); drain();

        // Two channels interleaved, random data.
        fixed_en = 1'b0;
        set_mask(4'b0000); set_mask(4'b1001); eoc_run = 1'b1; wait_reads(64); quiesce(); drain();

        // Random channel sets.
        for (int s = 0; s < 4; s++) begin
            m = 4'($urandom_range(1, 15));
            set_mask(4'b0000); set_mask(m); eoc_run = 1'b1;
            wait_reads(NSAMP * $countones(m) + int'($urandom_range(0, 10)));
            quiesce(); drain();
        end

        // Samples right at the noise floor.
        fixed_en = 1'b1; fixed_data = 16'h00F0;
        set_mask(4'b0000); set_mask(4'b0100); eoc_run = 1'b1; wait_reads(16); quiesce(); drain();
        fixed_en = 1'b0;

        // Enable loss mid-average, then re-enable.
        set_mask(4'b0000); set_mask(4'b0011); eoc_run = 1'b1; wait_reads(16); quiesce();
        set_mask(4'b0010); eoc_run = 1'b1; wait_reads(10); quiesce();
        set_mask(4'b0011); eoc_run = 1'b1; wait_reads(40); quiesce(); drain();

        // DRP read timeout: read abandoned, same channel re-read later.
        set_mask(4'b0000); set_mask(4'b0011);
        withhold = 1'b1; den0 = n_den;
        pulse_eoc();
        t = 0;
        while (n_den == den0 && t < 10) begin @(negedge clk); t++; end
        check("tmo_read_issued", 32'(n_den), 32'(den0 + 1));
        repeat (200) @(negedge clk);
        pulse_eoc();
        repeat (40) @(negedge clk);
        check("tmo_eoc_ignored", 32'(n_den), 32'(den0 + 1));
        repeat (60) @(negedge clk);
        withhold = 1'b0;
        pulse_eoc();
        wait_reads(1);
        check("tmo_reread", 32'(n_den), 32'(den0 + 2));
        eoc_run = 1'b1; wait_reads(40); quiesce(); drain();

        // Consumer stalled across two results.
        set_mask(4'b0000); set_mask(4'b0001);
        ready_mode = 0; drop_mode = 1'b1; held = 1'b0;
        eoc_run = 1'b1; wait_reads(32); quiesce();
        check("stall_valid", 32'(avg_valid), 32'(1));
        check("stall_overrun", 32'(overrun), 32'(exp_ovr));
        ready_mode = 1; drain();
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0; exp_ovr = 1'b0; drop_mode = 1'b0; held = 1'b0;
        @(negedge clk);
        check("overrun_cleared", 32'(overrun), 32'(exp_ovr));

        // Asynchronous reset in the middle of traffic.
        set_mask(4'b0000); set_mask(4'b1111); eoc_run = 1'b1; wait_reads(30);
        @(negedge clk);
        #2 rst_n = 1'b0;
        epoch++;
        eoc_run = 1'b0;
        exp_q.delete();
        exp_ovr = 1'b0;
        #1 check_reset("midrst");
        @(negedge clk);
        set_mask(4'b0000);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        set_mask(4'b1111); eoc_run = 1'b1; wait_reads(70); quiesce(); drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
